// File: rtl/booth_sched_pkg.sv
// Shared types and widths for the booth multiplier scheduler.
package booth_sched_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after ptr wins, wrapping at NREQ.
module rr_arbiter
    import booth_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    int w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_idx   = 0;
        // Scan from the farthest offset back to ptr so the nearest valid request is assigned last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (req[w_idx]) begin
                gnt        = '0;
                gnt[w_idx] = 1'b1;
                gnt_idx    = IW'(w_idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_sched.sv
// Round-robin scheduler sharing one booth 8x8 signed multiplier between NREQ requesters,
// returning each product tagged with its requester index, or an error on timeout.
module booth_sched
    import booth_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*OP_W-1:0]      req_a,
    input  logic [NREQ*OP_W-1:0]      req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic signed [RES_W-1:0]   rsp_data,
    output logic                      rsp_err,
    output logic                      mul_start,
    output logic signed [OP_W-1:0]    mul_a,
    output logic signed [OP_W-1:0]    mul_b,
    input  logic                      mul_done,
    input  logic signed [RES_W-1:0]   mul_result
);

    localparam int IDW   = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    sched_state_e            r_state;
    logic [IDW-1:0]          r_ptr;
    logic [IDW-1:0]          r_id;
    logic signed [OP_W-1:0]  r_a;
    logic signed [OP_W-1:0]  r_b;
    logic signed [RES_W-1:0] r_data;
    logic                    r_err;
    logic                    r_done;
    logic [CNT_W-1:0]        r_cnt;

    logic [NREQ-1:0]         w_gnt;
    logic [IDW-1:0]          w_gnt_idx;
    logic                    w_any;
    logic signed [OP_W-1:0]  w_a;
    logic signed [OP_W-1:0]  w_b;
    logic                    w_done_rise;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    assign w_a         = req_a[int'(w_gnt_idx)*OP_W +: OP_W];
    assign w_b         = req_b[int'(w_gnt_idx)*OP_W +: OP_W];
    assign w_done_rise = mul_done & ~r_done;

    // Gated by rst so the combinational grant cannot leak out while reset is held.
    assign req_ready = (rst && r_state == IDLE) ? w_gnt : '0;
    assign mul_start = (r_state == ISSUE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;
    assign rsp_err   = r_err;
    assign mul_a     = r_a;
    assign mul_b     = r_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= mul_done;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_id    <= w_gnt_idx;
                        r_ptr   <= (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + IDW'(1);
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Only a fresh edge counts: a done level left high by the previous operation is ignored.
                    if (w_done_rise) begin
                        r_data  <= mul_result;
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_data  <= '0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_sched.sv
// Scoreboard bench for booth_sched with a behavioural multiplier model and random requesters.
module tb_booth_sched;

    localparam int NREQ = 4;
    localparam int TO   = 8;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [15:0]       rsp_data;
    logic              rsp_err;
    logic              mul_start;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic              mul_done;
    logic [15:0]       mul_result;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    booth_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Behavioural multiplier: random latency 1..6, done held high until the next start.
    logic        stub_hang;
    logic [15:0] s_prod;
    int          s_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_done   <= 1'b0;
            mul_result <= '0;
            s_prod     <= '0;
            s_cnt      <= 0;
        end else if (mul_start) begin
            mul_done   <= 1'b0;
            mul_result <= 16'($urandom);
            s_prod     <= $signed(mul_a) * $signed(mul_b);
            s_cnt      <= stub_hang ? 0 : int'($urandom_range(1, 6));
        end else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
            if (s_cnt == 1) begin
                mul_done   <= 1'b1;
                mul_result <= s_prod;
            end
        end
    end

    // Reference model and monitor
    exp_t        sbq[$];
    int          glog[$];
    logic [31:0] rlog[$];
    logic [NREQ-1:0] hs_vec;
    logic [NREQ-1:0] exp_rdy;
    logic        hang_next;
    bit          mbusy, waiting, in_rsp, prev_done;
    int          mptr, start_due, exp_rsp_cyc, g, pa, pb, prod, n_rsp_rise;
    logic [7:0]  exp_a, exp_b;
    logic [18:0] held;
    exp_t        e, eg;

    initial n_rsp_rise = 0;

    always @(negedge clk) begin
        if (!rst) begin
            mbusy = 0; mptr = 0; sbq.delete(); start_due = -1; waiting = 0;
            in_rsp = 0; prev_done = 0; hs_vec = '0; exp_rsp_cyc = -1;
        end else begin
            hs_vec  = req_valid & req_ready;
            exp_rdy = '0;
            g = -1;
            if (!mbusy)
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));

            if (waiting && mul_done && !prev_done) begin
                exp_rsp_cyc = cyc + 1;
                waiting = 0;
            end
            prev_done = mul_done;

            chk("mul_start", 64'(mul_start), 64'(cyc == start_due));
            if (cyc == start_due) begin
                chk("mul_a", 64'(mul_a), 64'(exp_a));
                chk("mul_b", 64'(mul_b), 64'(exp_b));
                waiting = !stub_hang;
            end

            if (g >= 0) begin
                exp_a   = req_a[g*8 +: 8];
                exp_b   = req_b[g*8 +: 8];
                pa      = int'($signed(exp_a));
                pb      = int'($signed(exp_b));
                prod    = pa * pb;
                eg.id   = 2'(g);
                eg.err  = hang_next;
                eg.data = hang_next ? 16'h0000 : prod[15:0];
                sbq.push_back(eg);
                stub_hang   = hang_next;
                mbusy       = 1;
                mptr        = (g + 1) % NREQ;
                glog.push_back(g);
                start_due   = cyc + 1;
                exp_rsp_cyc = hang_next ? cyc + 2 + TO : -1;
                waiting     = 0;
            end

            if (in_rsp) chk("rsp_valid_held", 64'(rsp_valid), 64'd1);
            if (rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp = 1;
                    n_rsp_rise++;
                    chk("rsp_expected", 64'(sbq.size() != 0), 64'd1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("rsp_id", 64'(rsp_id), 64'(e.id));
                        chk("rsp_data", 64'(rsp_data), 64'(e.data));
                        chk("rsp_err", 64'(rsp_err), 64'(e.err));
                        chk("rsp_cycle", 64'(cyc), 64'(exp_rsp_cyc));
                    end
                    held = {rsp_err, rsp_id, rsp_data};
                end else begin
                    chk("rsp_stable", 64'({rsp_err, rsp_id, rsp_data}), 64'(held));
                end
                if (rsp_ready) begin
                    in_rsp = 0;
                    mbusy  = 0;
                    rlog.push_back({13'd0, rsp_err, rsp_id, rsp_data});
                end
            end
        end
    end

    // Stimulus
    function automatic logic [7:0] pick_op();
        logic [7:0] edges [4];
        edges = '{8'h80, 8'h7F, 8'h00, 8'hFF};
        if ($urandom_range(0, 7) == 0) return edges[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    task automatic run(input int maxc, input int ngr, input logic [NREQ-1:0] mask,
                       input int vprob, input bit drop, input int rprob, input int hprob);
        int base;
        bit reached;
        base    = glog.size();
        reached = 0;
        for (int c = 0; c < maxc; c++) begin
            @(posedge clk); #1;
            if (ngr > 0 && glog.size() - base >= ngr) begin
                reached = 1;
                break;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!mask[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] || hs_vec[i]) begin
                    if (int'($urandom_range(0, 99)) < vprob) begin
                        req_valid[i]      = 1'b1;
                        req_a[i*8 +: 8]   = pick_op();
                        req_b[i*8 +: 8]   = pick_op();
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if (drop && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = (int'($urandom_range(0, 99)) < rprob);
            hang_next = (int'($urandom_range(0, 99)) < hprob);
        end
        if (ngr > 0) chk("grant_budget", 64'(reached), 64'd1);
    endtask

    task automatic drain(input int maxc);
        bit ok;
        ok = 0;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (!mbusy && sbq.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("drain", 64'(ok), 64'd1);
    endtask

    task automatic quiesce();
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        hang_next = 1'b0;
        drain(100);
    endtask

    task automatic send(input int id, input logic [7:0] a, input logic [7:0] b);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        req_valid[id]    = 1'b1;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (hs_vec[id]) begin
                ok = 1;
                break;
            end
        end
        chk("send_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic check_zero(input string name);
        chk(name, 64'({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mul_start, mul_a, mul_b}), 64'd0);
    endtask

    initial begin
        int n;
        bit ok;
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        hang_next = 1'b0;
        stub_hang = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        check_zero("reset_outputs");
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;

        // Fairness: all four held valid, then only 0 and 2.
        run(200, 4, 4'hF, 100, 0, 100, 0);
        chk("rr_all_0", 64'(glog[0]), 64'd0);
        chk("rr_all_1", 64'(glog[1]), 64'd1);
        chk("rr_all_2", 64'(glog[2]), 64'd2);
        chk("rr_all_3", 64'(glog[3]), 64'd3);
        run(200, 3, 4'h5, 100, 0, 100, 0);
        chk("rr_02_0", 64'(glog[4]), 64'd0);
        chk("rr_02_1", 64'(glog[5]), 64'd2);
        chk("rr_02_2", 64'(glog[6]), 64'd0);
        quiesce();

        // Single request and back-to-back requests with known products.
        n = rlog.size();
        send(0, 8'd25, 8'h92);
        drain(100);
        chk("single_rsp", 64'(rlog[n]), 64'h0000_F542);
        n = rlog.size();
        send(2, 8'd100, 8'hF4);
        send(1, 8'h80, 8'h80);
        drain(100);
        chk("b2b_first", 64'(rlog[n]), 64'h0002_FB50);
        chk("b2b_second", 64'(rlog[n+1]), 64'h0001_4000);

        // Response backpressure with another requester waiting.
        n = rlog.size();
        rsp_ready = 1'b0;
        send(3, 8'd7, 8'd9);
        req_valid[1] = 1'b1;
        req_a[15:8]  = 8'hFF;
        req_b[15:8]  = 8'd3;
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1;
                break;
            end
        end
        chk("bp_rsp_seen", 64'(ok), 64'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_data", 64'(rsp_data), 64'd63);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_no_start", 64'(mul_start), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (hs_vec[1]) begin
                ok = 1;
                break;
            end
        end
        chk("bp_next_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        drain(100);
        chk("bp_rsp_held", 64'(rlog[n]), 64'h0003_003F);
        chk("bp_rsp_next", 64'(rlog[n+1]), 64'h0001_FFFD);

        // Timeout, then a normal operation.
        n = rlog.size();
        hang_next = 1'b1;
        send(0, 8'd5, 8'd6);
        hang_next = 1'b0;
        drain(100);
        send(0, 8'd5, 8'd6);
        drain(100);
        chk("timeout_rsp", 64'(rlog[n]), 64'h0004_0000);
        chk("after_timeout_rsp", 64'(rlog[n+1]), 64'h0000_001E);

        // Reset while waiting on the multiplier.
        hang_next = 1'b1;
        send(2, 8'd3, 8'd4);
        hang_next = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n = n_rsp_rise;
        rst = 1'b0;
        #1;
        check_zero("midreset_outputs");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_rsp_after_reset", 64'(n_rsp_rise), 64'(n));
        n = glog.size();
        run(100, 1, 4'hF, 100, 0, 100, 0);
        chk("post_reset_grant", 64'(glog[n]), 64'd0);
        quiesce();

        // Random traffic with drops, backpressure and occasional hung multiplier.
        run(4000, 0, 4'hF, 30, 1, 70, 12);
        quiesce();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/booth_sched.md
# booth_sched

Round-robin scheduler that shares one `booth` 8×8 signed multiplier between NREQ requesters. It accepts an operand pair from one requester at a time and issues a one-cycle `start` to the multiplier. It waits for the multiplier's `done`, then returns the 16-bit product tagged with the requester index. It sits between the requesting datapath blocks and a single `booth` instance, and owns that instance's `start`/`A`/`B` inputs.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: cycles allowed in WAIT before the operation is aborted with an error.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester operand-pair valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit is high in any cycle.
- `req_a`  in  NREQ×8  packed multiplicands, slice i belongs to requester i.
- `req_b`  in  NREQ×8  packed multipliers, slice i belongs to requester i.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  $clog2(NREQ)  index of the requester that owns the response.
- `rsp_data`  out  16  signed product.
- `rsp_err`  out  1  response produced by timeout; `rsp_data`=0.
- `mul_start`  out  1  to booth `start`.
- `mul_a`  out  8  to booth `A`.
- `mul_b`  out  8  to booth `B`.
- `mul_done`  in  1  from booth `done`.
- `mul_result`  in  16  from booth `outR`.

## Operation
- FSM states:
  - IDLE: if any `req_valid`, the arbiter picks grant g, `req_ready[g]`=1 combinationally, `req_a[g]`/`req_b[g]`/g are latched into `a_q`/`b_q`/`id_q`, next state ISSUE. Otherwise stay in IDLE.
  - ISSUE: `mul_start`=1 for exactly this cycle; clear the timeout counter; next state WAIT.
  - WAIT: on a rising edge of `mul_done` (`mul_done & ~done_q`), latch `mul_result` into `rsp_data`, set `rsp_err`=0, go to RESP. If the counter reaches TIMEOUT-1 first, set `rsp_data`=0 and `rsp_err`=1, go to RESP. Otherwise increment the counter.
  - RESP: `rsp_valid`=1. Hold `rsp_id`, `rsp_data` and `rsp_err` stable until `rsp_valid & rsp_ready`, then go to IDLE.
- `mul_a`/`mul_b` are driven from `a_q`/`b_q` continuously, so they are stable for the whole operation.
- `done_q` is registered every cycle. `mul_done` edges outside WAIT are ignored; this covers a stale level-high `done` left over from the previous operation.
- Round-robin arbitration:
  - Search starts at pointer `ptr`; the first valid index in the order ptr, ptr+1, …, wrapping at NREQ, wins.
  - On a grant, `ptr` ← (g+1) mod NREQ. `ptr` is unchanged when nothing is granted.
- `req_ready` is 0 in every state except IDLE, so a new request is never accepted while one is in flight.
- Products pass through unchanged: two's complement, full 16 bits, no truncation or sign manipulation.
- Reset values: state=IDLE; `ptr`=0; `a_q`, `b_q`, `id_q`, `rsp_data`, `rsp_err`, `done_q` and the counter are all 0. All outputs read 0 out of reset.
- Reset mid-operation discards the in-flight request with no response. The booth instance must share `rst`.

## Timing
- A request accepted in cycle T (`req_valid & req_ready`) gives `mul_start`=1 in cycle T+1.
- The WAIT counter starts counting in cycle T+2.
- Given a `done` rising edge in cycle D, `rsp_valid` rises in cycle D+1.
- With `rsp_ready` held at 1, the scheduler is back in IDLE at D+2 and can grant at D+2. Minimum overhead is therefore 4 cycles plus the multiplier latency.
- A timeout gives `rsp_valid` in cycle T+2+TIMEOUT.
- Requesters may drop `req_valid` before being granted; this is not a protocol error. After a handshake, the requester's operands need not be held.
- `rsp_valid` never drops without a handshake.

## Structure
- Package `booth_sched_pkg` holds:
  - the state enum `sched_state_e` {IDLE, ISSUE, WAIT, RESP};
  - `OP_W`=8 and `RES_W`=16.
- Sub-module `rr_arbiter`, parameterised by NREQ:
  - inputs: `req` vector, `ptr`;
  - outputs: one-hot `gnt`, encoded `gnt_idx`, `any`.
  - It is purely combinational; the scheduler owns the `ptr` register.

## Test plan
- Single request, with a real `booth`: requester 0 sends A=25, B=-110 (8'h92) → `mul_start` pulses once, then a response with `rsp_id`=0, `rsp_data`=16'hF542, `rsp_err`=0.
- Back-to-back requests: requester 2 sends A=100, B=-12, then requester 1 sends A=-128, B=-128 → responses 16'hFB50 (id 2) then 16'h4000 (id 1), in that order.
- Round-robin fairness: all four `req_valid` held high → grant order 0,1,2,3. Then only requesters 0 and 2 valid → grant order 0,2,0.
- Response backpressure: `rsp_ready` held low for 10 cycles → `rsp_valid`/`rsp_data` stay stable, `req_ready` stays 0, and there is no second `mul_start`.
- Timeout: a stub multiplier that never asserts `done`, TIMEOUT=8 → `rsp_valid` in cycle T+10 with `rsp_err`=1 and `rsp_data`=0. A subsequent request then completes normally.
- Reset mid-WAIT: assert `rst` low during WAIT → all outputs are 0 immediately, and after release the scheduler is in IDLE with `ptr`=0 and no response emitted.
